// File: rtl/fmap_sched_pkg.sv
// Shared types and default sizing for the feature-map BRAM write scheduler.
package fmap_sched_pkg;

  localparam int FMAP_NUM_REQ = 4;
  localparam int FMAP_ADDR_W  = 12;
  localparam int FMAP_DATA_W  = 256;
  localparam int FMAP_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    FINISHED = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fmap_bram_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmap_bram_scheduler.sv
// Shares one BRAM write port between NUM_REQ capture engines: one holding
// register per engine, round-robin grant, per-engine word counters.
module fmap_bram_scheduler
  import fmap_sched_pkg::*;
#(
  parameter int NUM_REQ = FMAP_NUM_REQ,
  parameter int ADDR_W  = FMAP_ADDR_W,
  parameter int DATA_W  = FMAP_DATA_W,
  parameter int CNT_W   = FMAP_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_REQ-1:0]          req_mask,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [ADDR_W-1:0]           bram_addr_a,
  output logic [DATA_W-1:0]           bram_wrdata_a,
  output logic                        bram_we_a,
  output logic                        busy,
  output logic                        write_done,
  output logic [NUM_REQ*CNT_W-1:0]    word_count,
  output logic                        overflow_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sched_state_t state, state_nx;

  logic [NUM_REQ-1:0] mask_q;
  logic [NUM_REQ-1:0] hold_v;
  logic [NUM_REQ-1:0] hold_last;
  logic [NUM_REQ-1:0] done_q;
  logic [ADDR_W-1:0]  hold_addr [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [CNT_W-1:0]   cnt       [NUM_REQ];
  logic [PW-1:0]      rr_ptr;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_v;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] accept;
  logic               start_acc;
  logic               all_done;
  logic               in_run;

  assign in_run    = (state == RUN);
  assign start_acc = start && !in_run;
  assign all_done  = ((done_q & mask_q) == mask_q);
  assign req_ready = {NUM_REQ{in_run}} & mask_q & ~hold_v & ~done_q;
  assign accept    = req_valid & req_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (hold_v),
    .ptr   (rr_ptr),
    .grant (gnt),
    .valid (gnt_v)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FINISHED: if (start) state_nx = RUN;
      RUN:            if (all_done) state_nx = FINISHED;
      default:        state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy       = 1'b0;
    write_done = 1'b0;
    case (state)
      RUN:      busy       = 1'b1;
      FINISHED: write_done = 1'b1;
      default:  ;
    endcase
  end

  // Payload of the holding registers needs no reset; hold_v qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
        hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        hold_last[i] <= req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q        <= '0;
      hold_v        <= '0;
      done_q        <= '0;
      rr_ptr        <= '0;
      overflow_err  <= 1'b0;
      bram_we_a     <= 1'b0;
      bram_addr_a   <= '0;
      bram_wrdata_a <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (start_acc) begin
      mask_q       <= req_mask;
      hold_v       <= '0;
      done_q       <= '0;
      rr_ptr       <= '0;
      overflow_err <= 1'b0;
      bram_we_a    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (in_run) begin
      bram_we_a <= gnt_v;
      if (gnt_v) begin
        bram_addr_a   <= hold_addr[gnt_idx];
        bram_wrdata_a <= hold_data[gnt_idx];
        rr_ptr        <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        // accept and grant are exclusive per requester since ready needs !hold_v
        if (accept[i])   hold_v[i] <= 1'b1;
        else if (gnt[i]) hold_v[i] <= 1'b0;
        if (gnt[i]) begin
          if (cnt[i] == CNT_MAX) overflow_err <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
          if (hold_last[i]) done_q[i] <= 1'b1;
        end
      end
    end else begin
      bram_we_a <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign word_count[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_fmap_bram_scheduler.sv
// Randomized bench for fmap_bram_scheduler with a behavioural model and
// directed passes whose outcomes are pinned by literal expectations.
module tb_fmap_bram_scheduler;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 256;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N-1:0]    req_mask;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [AW-1:0]   bram_addr_a;
  logic [DW-1:0]   bram_wrdata_a;
  logic            bram_we_a;
  logic            busy;
  logic            write_done;
  logic [N*CW-1:0] word_count;
  logic            overflow_err;

  fmap_bram_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .req_mask      (req_mask),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_last      (req_last),
    .bram_addr_a   (bram_addr_a),
    .bram_wrdata_a (bram_wrdata_a),
    .bram_we_a     (bram_we_a),
    .busy          (busy),
    .write_done    (write_done),
    .word_count    (word_count),
    .overflow_err  (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- word sources ----------------
  int src_n    [N];
  int src_sent [N];
  int valid_pct = 100;
  int pass_id   = 0;

  function automatic logic [AW-1:0] word_addr(input int i, input int k);
    return AW'(i * 256 + k);
  endfunction

  function automatic logic [DW-1:0] word_data(input int i, input int k);
    logic [31:0] w;
    w = 32'(pass_id * 32'h0100_0193) ^ 32'(i * 32'h0100_0000) ^ 32'(k * 32'h9E37_79B1);
    return {8{w}};
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      src_n[i]    = 0;
      src_sent[i] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (src_sent[i] < src_n[i] && int'($urandom_range(99)) < valid_pct) begin
          req_valid[i]             = 1'b1;
          req_addr[i*AW +: AW]     = word_addr(i, src_sent[i]);
          req_data[i*DW +: DW]     = word_data(i, src_sent[i]);
          req_last[i]              = (src_sent[i] == src_n[i] - 1);
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'($urandom_range(1));
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  int            m_st;      // 0 idle, 1 capturing, 2 finished
  bit [N-1:0]    m_mask, m_hv, m_done;
  bit            m_hl [N];
  logic [AW-1:0] m_ha [N];
  logic [DW-1:0] m_hd [N];
  int            m_cnt [N];
  int            m_ptr;
  bit            m_ovf, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            cyc = 0;

  function automatic bit m_ready(input int i);
    return (m_st == 1) && m_mask[i] && !m_hv[i] && !m_done[i];
  endfunction

  task automatic model_reset();
    m_st = 0; m_mask = '0; m_hv = '0; m_done = '0; m_ptr = 0;
    m_ovf = 0; m_we = 0; m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin : model
    bit [N-1:0] acc;
    bit         fin;
    int         w, j;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] && m_ready(i);
      if (m_st != 1 && start) begin
        m_st = 1; m_mask = req_mask; m_hv = '0; m_done = '0; m_ptr = 0;
        m_ovf = 0; m_we = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (m_st == 1) begin
        fin = ((m_done & m_mask) == m_mask);
        w = -1;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && m_hv[j]) w = j;
        end
        m_we = (w >= 0);
        if (w >= 0) begin
          m_addr = m_ha[w];
          m_data = m_hd[w];
          m_hv[w] = 1'b0;
          if (m_cnt[w] == CMAX) m_ovf = 1'b1;
          else                  m_cnt[w]++;
          if (m_hl[w]) m_done[w] = 1'b1;
          m_ptr = (w + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            m_hv[i] = 1'b1;
            m_ha[i] = req_addr[i*AW +: AW];
            m_hd[i] = req_data[i*DW +: DW];
            m_hl[i] = req_last[i];
            src_sent[i]++;
          end
        end
        if (fin) m_st = 2;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // ---------------- compare + event log ----------------
  int         we_cyc [$];
  logic [AW-1:0] we_addr [$];
  int         wd_rise = -1;
  int         ovf_rise = -1;
  int         busy_cnt = 0;
  int         odd_ready_seen = 0;
  bit         wd_prev = 0, ovf_prev = 0;

  always @(negedge clk) begin
    logic [N*CW-1:0] exp_wc;
    logic [N-1:0]    exp_rdy;
    if (cyc > 0) begin
      for (int i = 0; i < N; i++) begin
        exp_wc[i*CW +: CW] = CW'(m_cnt[i]);
        exp_rdy[i]         = m_ready(i);
      end
      chk("busy", DW'(busy), DW'(m_st == 1));
      chk("write_done", DW'(write_done), DW'(m_st == 2));
      chk("bram_we_a", DW'(bram_we_a), DW'(m_we));
      chk("bram_addr_a", DW'(bram_addr_a), DW'(m_addr));
      chk("bram_wrdata_a", bram_wrdata_a, m_data);
      chk("word_count", DW'(word_count), DW'(exp_wc));
      chk("overflow_err", DW'(overflow_err), DW'(m_ovf));
      chk("req_ready", DW'(req_ready), DW'(exp_rdy));
      if (bram_we_a === 1'b1) begin
        we_cyc.push_back(cyc);
        we_addr.push_back(bram_addr_a);
      end
      if (write_done === 1'b1 && !wd_prev) wd_rise = cyc;
      if (overflow_err === 1'b1 && !ovf_prev) ovf_rise = cyc;
      if (busy === 1'b1) busy_cnt++;
      if (req_ready[1] === 1'b1 || req_ready[3] === 1'b1) odd_ready_seen++;
      wd_prev  = (write_done === 1'b1);
      ovf_prev = (overflow_err === 1'b1);
    end
  end

  // ---------------- sequencing tasks ----------------
  task automatic start_pass(input logic [N-1:0] mask, input int n0, input int n1,
                            input int n2, input int n3, input int vp);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) src_n[i] = 0;
    @(posedge clk);
    #1;
    pass_id++;
    src_n[0] = n0; src_n[1] = n1; src_n[2] = n2; src_n[3] = n3;
    for (int i = 0; i < N; i++) src_sent[i] = 0;
    valid_pct = vp;
    we_cyc.delete();
    we_addr.delete();
    wd_rise = -1; ovf_rise = -1; busy_cnt = 0; odd_ready_seen = 0;
    start    = 1'b1;
    req_mask = mask;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int limit);
    int c = 0;
    while (write_done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (write_done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: write_done not seen within %0d cycles, required 1", name, limit);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] rmask;
    rst = 1'b1; start = 1'b0; req_mask = '0;
    req_valid = '0; req_addr = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(write_done), DW'(0));
    chk("rst_we", DW'(bram_we_a), DW'(0));
    chk("rst_wc", DW'(word_count), DW'(0));
    chk("rst_ovf", DW'(overflow_err), DW'(0));
    chk("rst_ready", DW'(req_ready), DW'(0));
    rst = 1'b0;

    // single requester, valid held high
    start_pass(4'b0001, 24, 0, 0, 0, 100);
    wait_finish("t1", 200);
    chk("t1_pulses", DW'(we_cyc.size()), DW'(24));
    if (we_cyc.size() == 24) begin
      for (int k = 0; k < 24; k++) chk("t1_addr", DW'(we_addr[k]), DW'(k));
      for (int k = 1; k < 24; k++) chk("t1_spacing", DW'(we_cyc[k] - we_cyc[k-1]), DW'(2));
      chk("t1_done_lat", DW'(wd_rise - we_cyc[23]), DW'(1));
    end
    chk("t1_wc0", DW'(word_count[7:0]), DW'(24));

    // four requesters saturating the port
    start_pass(4'b1111, 3, 3, 3, 3, 100);
    wait_finish("t2", 200);
    chk("t2_pulses", DW'(we_cyc.size()), DW'(12));
    if (we_cyc.size() == 12) begin
      for (int k = 0; k < 12; k++) chk("t2_order", DW'(we_addr[k][9:8]), DW'(k % 4));
      for (int k = 1; k < 12; k++) chk("t2_back2back", DW'(we_cyc[k] - we_cyc[k-1]), DW'(1));
    end
    chk("t2_wc", DW'(word_count), DW'(32'h0303_0303));

    // masked-off requesters present valid but are never served
    start_pass(4'b0101, 4, 5, 6, 7, 100);
    wait_finish("t3", 200);
    chk("t3_pulses", DW'(we_cyc.size()), DW'(10));
    chk("t3_odd_ready", DW'(odd_ready_seen), DW'(0));
    chk("t3_wc", DW'(word_count), DW'(32'h0006_0004));

    // empty mask finishes after one busy cycle
    start_pass(4'b0000, 2, 2, 2, 2, 100);
    wait_finish("t4", 20);
    chk("t4_busy_cycles", DW'(busy_cnt), DW'(1));
    chk("t4_pulses", DW'(we_cyc.size()), DW'(0));

    // counter saturation: 260 words into an 8-bit counter
    start_pass(4'b0001, 260, 0, 0, 0, 100);
    wait_finish("t5", 1000);
    chk("t5_pulses", DW'(we_cyc.size()), DW'(260));
    chk("t5_wc0", DW'(word_count[7:0]), DW'(255));
    chk("t5_ovf", DW'(overflow_err), DW'(1));
    if (we_cyc.size() == 260) chk("t5_ovf_at_256th", DW'(ovf_rise), DW'(we_cyc[255]));

    // reset in the middle of a pass
    start_pass(4'b1111, 8, 8, 8, 8, 100);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_we", DW'(bram_we_a), DW'(0));
    chk("t6_done", DW'(write_done), DW'(0));
    chk("t6_busy", DW'(busy), DW'(0));
    chk("t6_wc", DW'(word_count), DW'(0));
    rst = 1'b0;
    start_pass(4'b1010, 0, 5, 0, 3, 70);
    wait_finish("t6b", 300);
    chk("t6_pulses", DW'(we_cyc.size()), DW'(8));
    chk("t6_wc_after", DW'(word_count), DW'(32'h0300_0500));

    // randomized passes, with a start pulse during the pass that must be ignored
    for (int p = 0; p < 10; p++) begin
      rmask = N'($urandom_range(1, 15));
      start_pass(rmask, $urandom_range(1, 12), $urandom_range(1, 12),
                 $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(30, 100));
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      if (m_st == 1) begin
        start    = 1'b1;
        req_mask = ~rmask;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_finish("rand", 500);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
